// File: rtl/data_mem_responder.sv
// data_mem_responder
//
// Word-addressed data memory that answers a core's load/store requests after
// a fixed number of wait states. The request is captured in IDLE. The block
// then counts down WAIT_CYCLES in WAIT. It performs the access on the edge
// that enters RESP, and pulses MemAck for the single RESP cycle.
//
// Parameters:
//   DEPTH        number of 32-bit words (power of two, 2..4096)
//   WAIT_CYCLES  wait states before each access (0..15)
//
// Ports:
//   clk        single clock, rising edge
//   reset      asynchronous, active-low reset
//   MemReq     request valid, held by the core until MemAck
//   MemWrite   1 = store, 0 = load (sampled with MemReq)
//   Addr       word address
//   WriteData  store data
//   ReadData   registered load data, held on stores and while idle
//   MemAck     one-cycle completion pulse
//   Busy       high whenever the FSM is not in IDLE
//   AddrErr    out-of-range flag, meaningful only while MemAck=1
//
// Optional feature (macro DMEM_RANGE_CHECK_EN):
//   When defined, any access with Addr >= DEPTH is flagged with AddrErr.
//   Its store is dropped, and its load returns 0. When undefined, the
//   address wraps modulo DEPTH and AddrErr is tied to 0.

module data_mem_responder #(
  parameter int DEPTH       = 64,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemReq,
  input  logic        MemWrite,
  input  logic [31:0] Addr,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        MemAck,
  output logic        Busy,
  output logic        AddrErr
);

  localparam int   AW        = $clog2(DEPTH);
  localparam logic ZERO_WAIT = (WAIT_CYCLES == 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic        write_q;
  logic        addr_err_q;

  logic [31:0] mem [DEPTH];

  logic          access_en;
  logic [31:0]   acc_addr;
  logic [31:0]   acc_wdata;
  logic          acc_write;
  logic [AW-1:0] acc_idx;
  logic          in_range;

  // Decides whether the coming edge enters RESP, and hence performs the
  // access. With zero wait states, the capture edge itself enters RESP. The
  // live inputs are then the values being captured, so they are used
  // directly. In every other case, only the captured copies are used.
  always_comb begin
    access_en = 1'b0;
    acc_addr  = addr_q;
    acc_wdata = wdata_q;
    acc_write = write_q;
    case (state)
      IDLE: begin
        if (MemReq && ZERO_WAIT) begin
          access_en = 1'b1;
          acc_addr  = Addr;
          acc_wdata = WriteData;
          acc_write = MemWrite;
        end
      end
      WAIT:    access_en = (cnt == 4'd1);
      default: access_en = 1'b0;
    endcase
  end

  assign acc_idx = acc_addr[AW-1:0];

`ifdef DMEM_RANGE_CHECK_EN
  assign in_range = (acc_addr < 32'(DEPTH));
  assign AddrErr  = addr_err_q;
`else
  // The address wraps modulo DEPTH, so the upper address bits are
  // intentionally ignored.
  logic unused_bits;
  assign in_range    = 1'b1;
  assign AddrErr     = 1'b0;
  assign unused_bits = ^{acc_addr[31:AW], addr_err_q};
`endif

  // The memory array is not reset. The write is gated by reset, so an edge
  // seen while reset is asserted can never commit a store.
  always_ff @(posedge clk) begin
    if (reset && access_en && acc_write && in_range) begin
      mem[acc_idx] <= acc_wdata;
    end
  end

  // Control FSM with registered outputs. MemAck and AddrErr are raised on
  // the edge that enters RESP and cleared on every other edge. As a result,
  // they are high for exactly the RESP cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      cnt        <= 4'd0;
      addr_q     <= '0;
      wdata_q    <= '0;
      write_q    <= 1'b0;
      ReadData   <= '0;
      MemAck     <= 1'b0;
      addr_err_q <= 1'b0;
    end else begin
      MemAck     <= 1'b0;
      addr_err_q <= 1'b0;
      case (state)
        IDLE: begin
          if (MemReq) begin
            addr_q  <= Addr;
            wdata_q <= WriteData;
            write_q <= MemWrite;
            cnt     <= 4'(WAIT_CYCLES);
            state   <= ZERO_WAIT ? RESP : WAIT;
          end
        end
        WAIT: begin
          // cnt is always >= 1 here, so the decrement never wraps.
          cnt <= cnt - 4'd1;
          if (cnt == 4'd1) begin
            state <= RESP;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase

      if (access_en) begin
        MemAck     <= 1'b1;
        addr_err_q <= !in_range;
        if (!acc_write) begin
          ReadData <= in_range ? mem[acc_idx] : 32'd0;
        end
      end
    end
  end

  assign Busy = (state != IDLE);

endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder
//
// Directed bench for data_mem_responder. Instance dut uses the default
// parameters (DEPTH=64, WAIT_CYCLES=2). Instance dutZero uses
// WAIT_CYCLES=0 to exercise back-to-back requests. Inputs are driven and
// outputs are sampled on the falling edge of the clock.

module tb_data_mem_responder;

  logic        clk;
  logic        reset;

  logic        memReq;
  logic        memWrite;
  logic [31:0] addr;
  logic [31:0] writeData;
  logic [31:0] readData;
  logic        memAck;
  logic        busy;
  logic        addrErr;

  logic        memReq0;
  logic        memWrite0;
  logic [31:0] addr0;
  logic [31:0] writeData0;
  logic [31:0] readData0;
  logic        memAck0;
  logic        busy0;
  logic        addrErr0;

  int compared   = 0;
  int mismatched = 0;

  data_mem_responder dut (
    .clk       (clk),
    .reset     (reset),
    .MemReq    (memReq),
    .MemWrite  (memWrite),
    .Addr      (addr),
    .WriteData (writeData),
    .ReadData  (readData),
    .MemAck    (memAck),
    .Busy      (busy),
    .AddrErr   (addrErr)
  );

  data_mem_responder #(.DEPTH(64), .WAIT_CYCLES(0)) dutZero (
    .clk       (clk),
    .reset     (reset),
    .MemReq    (memReq0),
    .MemWrite  (memWrite0),
    .Addr      (addr0),
    .WriteData (writeData0),
    .ReadData  (readData0),
    .MemAck    (memAck0),
    .Busy      (busy0),
    .AddrErr   (addrErr0)
  );

  // Free-running clock with a 10-unit period.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Guard so that a stuck design still ends the run.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it if the observed value differs.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Presents a request to the default instance immediately.
  task automatic applyStimulus(input logic w, input logic [31:0] a, input logic [31:0] d);
    memReq    = 1'b1;
    memWrite  = w;
    addr      = a;
    writeData = d;
  endtask

  // Counts falling edges until MemAck, capped so it cannot hang. Returns
  // at the ack falling edge with the request dropped.
  task automatic waitAck(output int latency);
    latency = 0;
    do begin
      @(negedge clk);
      latency++;
    end while (!memAck && latency < 20);
    memReq = 1'b0;
  endtask

  initial begin
    int lat;
    int acks;

    reset      = 1'b0;
    memReq     = 1'b0;
    memWrite   = 1'b0;
    addr       = '0;
    writeData  = '0;
    memReq0    = 1'b0;
    memWrite0  = 1'b0;
    addr0      = '0;
    writeData0 = '0;

    // Reset state of both instances.
    repeat (2) @(negedge clk);
    checkOutput("rst_ack",   32'(memAck),   32'd0);
    checkOutput("rst_busy",  32'(busy),     32'd0);
    checkOutput("rst_rdata", readData,      32'd0);
    checkOutput("rst_err",   32'(addrErr),  32'd0);
    checkOutput("rst0_ack",  32'(memAck0),  32'd0);
    checkOutput("rst0_busy", 32'(busy0),    32'd0);
    checkOutput("rst0_rdata", readData0,    32'd0);

    // Release reset and request at the same time. The first rising edge
    // captures the store.
    reset = 1'b1;
    applyStimulus(1'b1, 32'd5, 32'hDEADBEEF);
    waitAck(lat);
    checkOutput("store5_latency", 32'(lat), 32'd3);
    checkOutput("store5_rdata_hold", readData, 32'd0);
    checkOutput("store5_err", 32'(addrErr), 32'd0);

    @(negedge clk);
    applyStimulus(1'b0, 32'd5, 32'd0);
    waitAck(lat);
    checkOutput("load5_latency", 32'(lat), 32'd3);
    checkOutput("load5_rdata", readData, 32'hDEADBEEF);

    @(negedge clk);
    checkOutput("idle_ack", 32'(memAck), 32'd0);
    checkOutput("idle_busy", 32'(busy), 32'd0);
    checkOutput("idle_rdata_hold", readData, 32'hDEADBEEF);

    // A store that is aborted by reset during WAIT must not commit.
    @(negedge clk);
    applyStimulus(1'b1, 32'd7, 32'h11);
    waitAck(lat);
    checkOutput("store7_latency", 32'(lat), 32'd3);
    @(negedge clk);
    applyStimulus(1'b1, 32'd7, 32'h22);
    @(negedge clk);
    checkOutput("abort_busy_wait", 32'(busy), 32'd1);
    checkOutput("abort_ack_wait", 32'(memAck), 32'd0);
    reset  = 1'b0;
    memReq = 1'b0;
    #1;
    checkOutput("abort_busy_rst", 32'(busy), 32'd0);
    checkOutput("abort_rdata_rst", readData, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    acks  = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (memAck) acks++;
    end
    checkOutput("abort_no_ack", 32'(acks), 32'd0);
    applyStimulus(1'b0, 32'd7, 32'd0);
    waitAck(lat);
    checkOutput("load7_latency", 32'(lat), 32'd3);
    checkOutput("load7_rdata", readData, 32'h11);

    // Input changes during WAIT must not disturb the access in flight.
    @(negedge clk);
    applyStimulus(1'b1, 32'd2, 32'hA5);
    waitAck(lat);
    @(negedge clk);
    applyStimulus(1'b1, 32'd9, 32'h99);
    waitAck(lat);
    @(negedge clk);
    applyStimulus(1'b0, 32'd2, 32'd0);
    @(negedge clk);
    addr      = 32'd9;
    writeData = 32'hFFFF_FFFF;
    memWrite  = 1'b1;
    memReq    = 1'b0;
    waitAck(lat);
    checkOutput("chg_load_latency", 32'(lat), 32'd2);
    checkOutput("chg_load_rdata", readData, 32'hA5);
    @(negedge clk);
    applyStimulus(1'b0, 32'd9, 32'd0);
    waitAck(lat);
    checkOutput("chg_mem9_intact", readData, 32'h99);

    @(negedge clk);
    applyStimulus(1'b1, 32'd12, 32'h1234);
    @(negedge clk);
    addr      = 32'd13;
    writeData = 32'h0BAD;
    memWrite  = 1'b0;
    waitAck(lat);
    @(negedge clk);
    applyStimulus(1'b0, 32'd12, 32'd0);
    waitAck(lat);
    checkOutput("chg_store_data", readData, 32'h1234);

`ifdef DMEM_RANGE_CHECK_EN
    // An out-of-range load is flagged and returns zero.
    @(negedge clk);
    applyStimulus(1'b0, 32'd64, 32'd0);
    waitAck(lat);
    checkOutput("range_err", 32'(addrErr), 32'd1);
    checkOutput("range_rdata", readData, 32'd0);
    @(negedge clk);
    checkOutput("range_err_clear", 32'(addrErr), 32'd0);
`else
    // Out-of-range addresses wrap modulo DEPTH.
    @(negedge clk);
    applyStimulus(1'b1, 32'd65, 32'h5A);
    waitAck(lat);
    checkOutput("wrap_store_err", 32'(addrErr), 32'd0);
    @(negedge clk);
    applyStimulus(1'b0, 32'd1, 32'd0);
    waitAck(lat);
    checkOutput("wrap_load_rdata", readData, 32'h5A);
    checkOutput("wrap_load_err", 32'(addrErr), 32'd0);
`endif

    // Reset in the middle of a RESP cycle clears every output.
    @(negedge clk);
    applyStimulus(1'b0, 32'd2, 32'd0);
    waitAck(lat);
    checkOutput("resp_ack_before_rst", 32'(memAck), 32'd1);
    reset = 1'b0;
    #1;
    checkOutput("resp_rst_ack", 32'(memAck), 32'd0);
    checkOutput("resp_rst_busy", 32'(busy), 32'd0);
    checkOutput("resp_rst_rdata", readData, 32'd0);
    checkOutput("resp_rst_err", 32'(addrErr), 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Zero wait states with MemReq held high, alternating store and load
    // to address 3. An ack is expected on every second cycle.
    @(negedge clk);
    memReq0    = 1'b1;
    memWrite0  = 1'b1;
    addr0      = 32'd3;
    writeData0 = 32'h33;
    @(negedge clk);
    checkOutput("w0_ack_store1", 32'(memAck0), 32'd1);
    checkOutput("w0_busy_resp", 32'(busy0), 32'd1);
    memWrite0 = 1'b0;
    @(negedge clk);
    checkOutput("w0_gap1", 32'(memAck0), 32'd0);
    checkOutput("w0_busy_gap", 32'(busy0), 32'd0);
    @(negedge clk);
    checkOutput("w0_ack_load1", 32'(memAck0), 32'd1);
    checkOutput("w0_load1_rdata", readData0, 32'h33);
    memWrite0  = 1'b1;
    writeData0 = 32'h44;
    @(negedge clk);
    checkOutput("w0_gap2", 32'(memAck0), 32'd0);
    @(negedge clk);
    checkOutput("w0_ack_store2", 32'(memAck0), 32'd1);
    checkOutput("w0_store2_rdata_hold", readData0, 32'h33);
    memWrite0 = 1'b0;
    @(negedge clk);
    checkOutput("w0_gap3", 32'(memAck0), 32'd0);
    @(negedge clk);
    checkOutput("w0_ack_load2", 32'(memAck0), 32'd1);
    checkOutput("w0_load2_rdata", readData0, 32'h44);
    memReq0 = 1'b0;
    @(negedge clk);
    checkOutput("w0_final_ack", 32'(memAck0), 32'd0);
    checkOutput("w0_final_busy", 32'(busy0), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 64, meaning the number of 32-bit words stored (power of two, 2..4096).
REQ-002 The block SHALL have parameter WAIT_CYCLES, default 2, meaning the wait states inserted before each access (0..15).
REQ-003 The block SHALL have port clk  input  1  single clock; all state is updated on its rising edge.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-005 The block SHALL have port MemReq  input  1  request valid, held by the core until MemAck.
REQ-006 The block SHALL have port MemWrite  input  1  1 = store, 0 = load; sampled with MemReq.
REQ-007 The block SHALL have port Addr  input  32  word address (word-addressed, not byte-addressed).
REQ-008 The block SHALL have port WriteData  input  32  store data.
REQ-009 The block SHALL have port ReadData  output  32  load data; registered.
REQ-010 The block SHALL have port MemAck  output  1  one-cycle completion pulse.
REQ-011 The block SHALL have port Busy  output  1  high whenever the state is not IDLE.
REQ-012 The block SHALL have port AddrErr  output  1  out-of-range flag, valid only while MemAck=1.

Function
REQ-013 The FSM SHALL have three states: IDLE, WAIT and RESP.
REQ-014 In IDLE with MemReq=1 at an edge, the block SHALL capture Addr, WriteData and MemWrite, load the wait counter with WAIT_CYCLES, and go to WAIT; if WAIT_CYCLES=0 it SHALL go directly to RESP.
REQ-015 In WAIT, each edge SHALL decrement the counter; the edge at which the counter equals 1 SHALL transition to RESP.
REQ-016 The memory access SHALL occur on the edge that enters RESP, using only the captured values: a store writes mem[addr_q], and a load registers mem[addr_q] into ReadData.
REQ-017 MemAck SHALL be 1 for exactly the one cycle spent in RESP, and RESP SHALL always return to IDLE on the next edge.
REQ-018 Latency SHALL be WAIT_CYCLES+1 cycles from the capture edge to the cycle in which MemAck is high.
REQ-019 A MemReq sampled in RESP SHALL be ignored, so back-to-back requests are accepted one cycle after MemAck, i.e. a throughput of one access per WAIT_CYCLES+2 cycles.
REQ-020 Changes on MemReq, Addr or WriteData during WAIT or RESP SHALL NOT affect the transaction in flight.
REQ-021 ReadData SHALL hold its value on store responses and while idle.
REQ-022 A load from an address written by the immediately preceding store SHALL return the new data.
REQ-023 The wait counter SHALL be 4 bits wide and SHALL never wrap: it decrements only in WAIT.

Reset
REQ-024 While reset=0, the block SHALL force state=IDLE, counter=0, MemAck=0, Busy=0, ReadData=0 and AddrErr=0, asynchronously.
REQ-025 Reset SHALL NOT initialize the memory array, whose contents are undefined until written.
REQ-026 Reset asserted during WAIT SHALL abort the transaction, so that a pending store is not performed and no MemAck is issued.
REQ-027 Reset deassertion SHALL take effect at the first rising edge of clk, and a request SHALL be acceptable at that edge.

Configuration
REQ-028 With macro DMEM_RANGE_CHECK_EN defined, an access with Addr >= DEPTH SHALL suppress the write, respond with ReadData=0 on loads, and assert AddrErr=1 together with MemAck.
REQ-029 Without DMEM_RANGE_CHECK_EN, the block SHALL use only Addr[log2(DEPTH)-1:0] (modulo wrap), and AddrErr SHALL be tied to 0.

Verification
REQ-030 Defaults: store 0xDEADBEEF to 5, then load 5 -> MemAck high 3 cycles after each capture edge, and ReadData=0xDEADBEEF in the load's ack cycle.
REQ-031 WAIT_CYCLES=0: hold MemReq continuously, alternating store/load to 3 -> an ack every 2nd cycle, and the load returns the stored value.
REQ-032 Store 0x11 to 7, then assert reset for one cycle during WAIT of a store 0x22 to 7, then load 7 -> the aborted store produces no ack, and the load returns 0x11.
REQ-033 Change Addr from 2 to 9 during WAIT of a load from 2 (mem[2]=0xA5) -> ReadData=0xA5.
REQ-034 DEPTH=64 with DMEM_RANGE_CHECK_EN: load 64 -> AddrErr=1 and ReadData=0; without the macro, store 0x5A to 65, then load 1 -> 0x5A with AddrErr=0.
REQ-035 Reset: all outputs are 0 while reset=0, including in the middle of a RESP cycle.
